key_event_encoder: RTL and testbench
====================================

// Module: key_event_encoder
// PURPOSE
//  Sits between camera_ctrl (key_down bitmap) and uart_ctrl. Once per camera frame it samples
//  the 40-bit key_down map and debounces each key over DEBOUNCE consecutive samples.
//  Each debounced press/release becomes a 1-byte event, queued in a FIFO and handed to the
//  UART sender over a valid/ready handshake. The PC thus receives note on/off events
//  instead of raw bitmaps.
// PARAMETERS
//  NUM_KEYS    40  keys in key_down; max 128
//  DEBOUNCE    3   consecutive differing samples before a key flips; 1 = immediate
//  FIFO_DEPTH  16  event FIFO entries; power of two
// PORTS
//  clk          in   1         system clock (clk24 domain)
//  rst          in   1         asynchronous reset, active-low
//  key_down     in   NUM_KEYS  raw key map from camera_ctrl, stable when sample pulses
//  sample       in   1         1-cycle strobe, one per frame
//  tx_data      out  8         event byte: [7]=1 press / 0 release, [6:0]=key index
//  tx_valid     out  1         tx_data valid (FIFO non-empty)
//  tx_ready     in   1         consumer accepts; transfer when tx_valid && tx_ready
//  stable_keys  out  NUM_KEYS  debounced key state, for UI/debug
//  busy         out  1         scan in progress
//  overflow     out  1         sticky: an event was dropped because FIFO was full
// BEHAVIOUR
//  Reset (rst=0, async):
//   - all outputs 0; stable_keys=0; all counters 0; FIFO empty; FSM in IDLE.
//  FSM states:
//   - IDLE: on sample=1, latch key_down into snap, idx<=0, go to SCAN.
//   - SCAN: one key per cycle, idx 0..NUM_KEYS-1. After idx==NUM_KEYS-1, return to IDLE.
//   - busy=1 only in SCAN.
//   - sample asserted in SCAN is ignored; that frame is lost and the scan is not restarted.
//  Debounce, per key k, evaluated in the cycle idx==k:
//   - snap[k]==stable[k]: cnt[k]<=0.
//   - otherwise, if cnt[k]+1==DEBOUNCE: stable[k]<=snap[k], cnt[k]<=0, push event
//     {snap[k], k[6:0]}.
//   - otherwise cnt[k]<=cnt[k]+1.
//   - cnt width = clog2(DEBOUNCE+1). A glitch shorter than DEBOUNCE samples leaves no event.
//  Latency (sample high in cycle t):
//   - key k is evaluated in cycle t+1+k.
//   - its event is visible on tx_valid/tx_data from t+2+k if the FIFO was empty; no bypass.
//   - Full scan occupies NUM_KEYS cycles; events leave in ascending key index order.
//  FIFO:
//   - first-word-fall-through; tx_data = head entry and holds while tx_valid && !tx_ready.
//   - Push and pop in the same cycle are both honoured, including when full (count unchanged)
//     and when empty-with-push (no pop occurs).
//   - Push when full with no pop: the event is dropped and overflow<=1. stable_keys still
//     updates, so the PC may miss one edge; overflow stays set until reset.
//   - Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
//  Reset asserted mid-scan or mid-transfer:
//   - immediate return to the reset state; queued events are discarded.
//   - tx_valid drops asynchronously.
// STRUCTURE
//  capiano_defs.vh (shared include):
//   - `NUM_KEYS (40).
//   - event encoding constants EV_PRESS=1'b1, EV_RELEASE=1'b0, EV_IDX_W=7.
//   - Reused by uart_ctrl and the PC-side decoder.
//  Sub-module sync_fifo #(WIDTH=8, DEPTH=FIFO_DEPTH):
//   - FWFT single-clock FIFO with full/empty/count.
//  Top-level logic:
//   - scan FSM, snap register, cnt array, stable array.
// TESTING
//  1 Reset: hold rst=0 with key_down=all ones and sample pulsing -> tx_valid=0,
//    stable_keys=0, overflow=0, busy=0.
//  2 Press: DEBOUNCE=3, key 5 high for 3 samples, tx_ready=1 -> exactly one byte 8'h85
//    after the 3rd scan; stable_keys[5]=1. Key 5 low for 3 samples -> 8'h05.
//  3 Glitch: key 12 high for 2 samples then low -> no event; cnt resets;
//    stable_keys[12] stays 0.
//  4 Ordering: keys 39, 0 and 7 rise together for 3 samples -> bytes 8'h80, 8'h87, 8'hA7
//    in that order. Byte 8'h80 appears on tx_valid at t+2 after the 3rd sample.
//  5 Backpressure/overflow: tx_ready=0, DEBOUNCE=1, FIFO_DEPTH=16, all 40 keys rise in one
//    frame -> 16 events queued (keys 0..15), overflow=1, stable_keys all ones. Then
//    tx_ready=1 -> 16 bytes 8'h80..8'h8F drain, tx_valid drops.
//  6 Sample during scan: pulse sample again 10 cycles after the first -> ignored; busy stays
//    high for exactly 40 cycles; no second scan starts.
//    Also assert rst=0 mid-scan -> outputs cleared immediately.

Source files
------------

// File: rtl/key_event_encoder_pkg.sv
// Shared types and constants for the key event encoder: event byte layout, scan FSM states, defaults.
package key_event_encoder_pkg;

  localparam int unsigned NUM_KEYS_DEF   = 40;
  localparam int unsigned DEBOUNCE_DEF   = 3;
  localparam int unsigned FIFO_DEPTH_DEF = 16;
  localparam int unsigned EV_IDX_W       = 7;

  localparam logic EV_PRESS   = 1'b1;
  localparam logic EV_RELEASE = 1'b0;

  typedef struct packed {
    logic                press;
    logic [EV_IDX_W-1:0] idx;
  } key_event_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

  function automatic key_event_t make_event(input logic press, input logic [EV_IDX_W-1:0] idx);
    key_event_t ev;
    ev.press = press;
    ev.idx   = idx;
    return ev;
  endfunction

endpackage

// File: rtl/key_event_encoder_sync_fifo.sv
// First-word-fall-through single-clock FIFO; simultaneous push/pop honoured when full.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign rd_data = mem_q[rd_ptr_q];
  assign do_rd   = rd_en && !empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign do_wr   = wr_en && (!full || do_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/key_event_encoder.sv
// Per-frame key map scanner: debounces each key and queues press/release event bytes for the UART.
module key_event_encoder
  import key_event_encoder_pkg::*;
#(
  parameter int unsigned NUM_KEYS   = NUM_KEYS_DEF,
  parameter int unsigned DEBOUNCE   = DEBOUNCE_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_down,
  input  logic                sample,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic [NUM_KEYS-1:0] stable_keys,
  output logic                busy,
  output logic                overflow
);
  localparam int unsigned IDX_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE + 1);
  localparam int unsigned CNT_XW = CNT_W + 1;

  scan_state_t         state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                snap_load;
  logic                eval;
  logic [NUM_KEYS-1:0] snap_q;
  logic [NUM_KEYS-1:0] stable_q;
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic                overflow_q;

  logic                key_snap;
  logic                key_stable;
  logic [CNT_W-1:0]    key_cnt;
  logic [CNT_XW-1:0]   cnt_inc;
  logic                flip;
  key_event_t          ev;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Scan sequencing: a sample seen while scanning is dropped, never restarts the scan.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_load = 1'b0;
    eval      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sample) begin
          state_d   = ST_SCAN;
          idx_d     = '0;
          snap_load = 1'b1;
        end
      end
      ST_SCAN: begin
        eval = 1'b1;
        if (idx_q == IDX_W'(NUM_KEYS - 1)) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign key_snap   = snap_q[idx_q];
  assign key_stable = stable_q[idx_q];
  assign key_cnt    = cnt_q[idx_q];
  assign cnt_inc    = {1'b0, key_cnt} + CNT_XW'(1);
  assign flip       = eval && (key_snap != key_stable) && (cnt_inc == CNT_XW'(DEBOUNCE));
  assign ev         = make_event(key_snap ? EV_PRESS : EV_RELEASE, EV_IDX_W'(idx_q));
  assign fifo_pop   = tx_valid && tx_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_q     <= '0;
      stable_q   <= '0;
      cnt_q      <= '{default: '0};
      overflow_q <= 1'b0;
    end else begin
      if (snap_load) begin
        snap_q <= key_down;
      end
      if (eval) begin
        if (key_snap == key_stable) begin
          cnt_q[idx_q] <= '0;
        end else if (flip) begin
          stable_q[idx_q] <= key_snap;
          cnt_q[idx_q]    <= '0;
        end else begin
          cnt_q[idx_q] <= key_cnt + CNT_W'(1);
        end
      end
      // Debounced state still advances when its event cannot be queued.
      if (flip && fifo_full && !fifo_pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH ($bits(key_event_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .wr_en   (flip),
    .wr_data (ev),
    .full    (fifo_full),
    .rd_en   (tx_ready),
    .rd_data (tx_data),
    .empty   (fifo_empty)
  );

  assign tx_valid    = !fifo_empty;
  assign stable_keys = stable_q;
  assign busy        = (state_q == ST_SCAN);
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_key_event_encoder.sv
// Randomized bench for key_event_encoder against a frame-level debounce and event-queue model.
module tb_key_event_encoder;

  localparam int unsigned NK    = 40;
  localparam int unsigned DEB   = 3;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NK-1:0] key_down = '0;
  logic          sample = 1'b0;
  logic          tx_ready = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic [NK-1:0] stable_keys;
  logic          busy;
  logic          overflow;

  key_event_encoder #(
    .NUM_KEYS   (NK),
    .DEBOUNCE   (DEB),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_down    (key_down),
    .sample      (sample),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .stable_keys (stable_keys),
    .busy        (busy),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: debounce outcome computed per frame, then replayed one key per cycle.
  bit         m_deb [NK];
  int         m_cnt [NK];
  bit         m_vis [NK];
  int         m_ev  [NK];
  bit         m_scan;
  int         m_pos;
  bit         m_ovf;
  logic [7:0] m_q [$];
  logic [7:0] got_q [$];

  function automatic logic [NK-1:0] vis_vec();
    logic [NK-1:0] v;
    for (int k = 0; k < NK; k++) v[k] = m_vis[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      m_deb[k] = 1'b0;
      m_cnt[k] = 0;
      m_vis[k] = 1'b0;
      m_ev[k]  = -1;
    end
    m_scan = 1'b0;
    m_pos  = 0;
    m_ovf  = 1'b0;
    m_q.delete();
  endtask

  task automatic model_edge(input logic smp, input logic [NK-1:0] kd, input logic rdy);
    if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
    if (m_scan) begin
      m_vis[m_pos] = m_deb[m_pos];
      if (m_ev[m_pos] >= 0) begin
        if (m_q.size() < DEPTH) m_q.push_back(8'(m_ev[m_pos]));
        else m_ovf = 1'b1;
      end
      m_pos++;
      if (m_pos == NK) m_scan = 1'b0;
    end else if (smp) begin
      for (int k = 0; k < NK; k++) begin
        m_ev[k] = -1;
        if (kd[k] == m_deb[k]) begin
          m_cnt[k] = 0;
        end else if (m_cnt[k] + 1 == DEB) begin
          m_deb[k] = kd[k];
          m_cnt[k] = 0;
          m_ev[k]  = (kd[k] ? 128 : 0) + k;
        end else begin
          m_cnt[k]++;
        end
      end
      m_scan = 1'b1;
      m_pos  = 0;
    end
  endtask

  // Called at a falling edge: compare outputs, drive inputs for the next rising edge, advance model.
  task automatic cycle(input logic smp, input logic [NK-1:0] kd, input logic rdy);
    check("tx_valid", 64'(tx_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) check("tx_data", 64'(tx_data), 64'(m_q[0]));
    check("busy", 64'(busy), 64'(m_scan));
    check("stable_keys", 64'(stable_keys), 64'(vis_vec()));
    check("overflow", 64'(overflow), 64'(m_ovf));
    sample   = smp;
    key_down = kd;
    tx_ready = rdy;
    if (tx_valid && tx_ready) got_q.push_back(tx_data);
    model_edge(smp, kd, rdy);
    @(negedge clk);
  endtask

  task automatic frame(input logic [NK-1:0] kd, input logic rdy);
    cycle(1'b1, kd, rdy);
    for (int i = 0; i < 43; i++) cycle(1'b0, kd, rdy);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NK-1:0] kd;
    int            busy_cnt;
    model_reset();

    // Reset held while inputs toggle.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      key_down = '1;
      sample   = 1'(i % 2);
      tx_ready = 1'b1;
      check("rst_tx_valid", 64'(tx_valid), 64'd0);
      check("rst_stable", 64'(stable_keys), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    key_down = '0;
    sample = 1'b0;
    @(negedge clk);

    // Press then release of key 5.
    got_q.delete();
    for (int f = 0; f < 3; f++) frame(40'h20, 1'b1);
    check("press_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() >= 1) check("press_byte", 64'(got_q[0]), 64'h85);
    check("press_stable5", 64'(stable_keys[5]), 64'd1);
    got_q.delete();
    for (int f = 0; f < 3; f++) frame(40'h0, 1'b1);
    check("release_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() >= 1) check("release_byte", 64'(got_q[0]), 64'h05);

    // Two-frame glitch on key 12 must never produce an event.
    got_q.delete();
    for (int f = 0; f < 2; f++) frame(40'h1000, 1'b1);
    for (int f = 0; f < 3; f++) frame(40'h0, 1'b1);
    for (int f = 0; f < 2; f++) frame(40'h1000, 1'b1);
    frame(40'h0, 1'b1);
    check("glitch_count", 64'(got_q.size()), 64'd0);
    check("glitch_stable12", 64'(stable_keys[12]), 64'd0);

    // Simultaneous presses leave in ascending key order.
    got_q.delete();
    for (int f = 0; f < 3; f++) frame(40'h80_0000_0081, 1'b1);
    check("order_count", 64'(got_q.size()), 64'd3);
    if (got_q.size() == 3) begin
      check("order_0", 64'(got_q[0]), 64'h80);
      check("order_1", 64'(got_q[1]), 64'h87);
      check("order_2", 64'(got_q[2]), 64'hA7);
    end
    for (int f = 0; f < 3; f++) frame(40'h0, 1'b1);

    // All keys press with the consumer stalled: FIFO fills, rest dropped.
    got_q.delete();
    for (int f = 0; f < 3; f++) frame('1, 1'b0);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_stable", 64'(stable_keys), 64'(40'hFF_FFFF_FFFF));
    check("ovf_no_pop", 64'(got_q.size()), 64'd0);
    for (int i = 0; i < 20; i++) cycle(1'b0, '1, 1'b1);
    check("drain_count", 64'(got_q.size()), 64'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < got_q.size()) check("drain_byte", 64'(got_q[i]), 64'(8'h80 + i));
    end
    check("drain_valid", 64'(tx_valid), 64'd0);

    // A second sample mid-scan is ignored; busy spans exactly one scan.
    cycle(1'b1, '1, 1'b1);
    busy_cnt = 0;
    for (int i = 1; i < 60; i++) begin
      if (busy) busy_cnt++;
      cycle(1'(i == 10), '1, 1'b1);
    end
    check("busy_cycles", 64'(busy_cnt), 64'd40);

    // Asynchronous reset in the middle of a scan with events queued.
    frame('0, 1'b0);
    frame('0, 1'b0);
    cycle(1'b1, '0, 1'b0);
    for (int i = 0; i < 15; i++) cycle(1'b0, '0, 1'b0);
    check("pre_rst_valid", 64'(tx_valid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 64'(tx_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_stable", 64'(stable_keys), 64'd0);
    check("mid_rst_overflow", 64'(overflow), 64'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    key_down = '0;
    sample = 1'b0;
    @(negedge clk);

    // Random key maps, sample spacing and consumer stalls.
    kd = '0;
    for (int f = 0; f < 120; f++) begin
      int          gap;
      int unsigned rdy_pct;
      logic [63:0] m;
      gap     = int'($urandom_range(20, 60));
      rdy_pct = $urandom_range(10, 100);
      m = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) kd = kd ^ NK'(m);
      cycle(1'b1, kd, 1'($urandom_range(0, 99) < rdy_pct));
      for (int i = 0; i < gap; i++) begin
        cycle(1'($urandom_range(0, 49) == 0), kd, 1'($urandom_range(0, 99) < rdy_pct));
      end
    end
    for (int i = 0; i < 60; i++) cycle(1'b0, kd, 1'b1);
    check("final_empty", 64'(tx_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
